mips32_fwd_hazard_unit: RTL and testbench

- Producer side of the EX-stage forwarding path.
- Generates registered ForwardA/ForwardB select codes for the two 3:1 forwarding muxes, one cycle ahead, while the instruction is still in ID.
- Tracks EX/MEM and MEM/WB destination shadow registers internally.
- Detects load-use hazards and issues a stall and bubble request to the PC, IF/ID and ID/EX control logic. Keeps a saturating stall-event counter.

---
 rtl/mips32_fwd_hazard_unit_if.sv | 25 ++
 rtl/mips32_fwd_hazard_unit.sv | 89 ++++++++
 tb/tb_mips32_fwd_hazard_unit.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/mips32_fwd_hazard_unit_if.sv
// ID-stage hazard/forwarding bundle: source fields and EX writer info in,
// registered forward selects, stall and stall counter out.
interface mips32_fwd_hazard_unit_if #(parameter int CNT_W = 16);
  logic             flush;
  logic [4:0]       id_rs;
  logic [4:0]       id_rt;
  logic             id_uses_rt;
  logic [4:0]       id_ex_rd;
  logic             id_ex_reg_write;
  logic             id_ex_mem_read;
  logic [1:0]       forward_a;
  logic [1:0]       forward_b;
  logic             stall;
  logic [CNT_W-1:0] stall_count;

  modport master (
    output flush, id_rs, id_rt, id_uses_rt, id_ex_rd, id_ex_reg_write, id_ex_mem_read,
    input  forward_a, forward_b, stall, stall_count
  );

  modport slave (
    input  flush, id_rs, id_rt, id_uses_rt, id_ex_rd, id_ex_reg_write, id_ex_mem_read,
    output forward_a, forward_b, stall, stall_count
  );
endinterface

// File: rtl/mips32_fwd_hazard_unit.sv
// Load-use stall and one-cycle-ahead EX forwarding select generation.
// Forward codes are registered so they line up with the EX cycle of the ID instruction.
module mips32_fwd_sel (
  input  logic [4:0] src,
  input  logic       en,
  input  logic       ex_rw,
  input  logic [4:0] ex_rd,
  input  logic       mem_rw,
  input  logic [4:0] mem_rd,
  output logic [1:0] code
);
  // EX writer is newest, so it beats the EX/MEM writer on a double match
  always_comb begin
    code = 2'b00;
    if (en && ex_rw && (ex_rd != 5'd0) && (ex_rd == src))
      code = 2'b10;
    else if (en && mem_rw && (mem_rd != 5'd0) && (mem_rd == src))
      code = 2'b01;
  end
endmodule

module mips32_fwd_hazard_unit #(
  parameter int CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  mips32_fwd_hazard_unit_if.slave hz
);
  localparam int NUM_SRC = 2;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic                      exmem_rw, memwb_rw;
  logic [4:0]                exmem_rd, memwb_rd;
  logic [NUM_SRC-1:0][4:0]   src;
  logic [NUM_SRC-1:0]        src_en;
  logic [NUM_SRC-1:0][1:0]   fwd_nxt;
  logic [NUM_SRC-1:0][1:0]   fwd_q;
  logic [CNT_W-1:0]          cnt_q;
  logic                      load_use;
  logic                      stall;

  assign src    = {hz.id_rt, hz.id_rs};
  assign src_en = {hz.id_uses_rt, 1'b1};

  genvar g;
  generate
    for (g = 0; g < NUM_SRC; g++) begin : g_src
      mips32_fwd_sel u_sel (
        .src    (src[g]),
        .en     (src_en[g]),
        .ex_rw  (hz.id_ex_reg_write),
        .ex_rd  (hz.id_ex_rd),
        .mem_rw (exmem_rw),
        .mem_rd (exmem_rd),
        .code   (fwd_nxt[g])
      );
    end
  endgenerate

  assign load_use = hz.id_ex_mem_read && hz.id_ex_reg_write && (hz.id_ex_rd != 5'd0) &&
                    ((hz.id_ex_rd == hz.id_rs) || (hz.id_uses_rt && (hz.id_ex_rd == hz.id_rt)));
  // A flushed ID instruction is discarded, so it cannot need a stall
  assign stall    = load_use && !hz.flush;

  // memwb shadow mirrors the real pipeline; write-before-read RF means no forward from it
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      exmem_rw <= 1'b0;
      exmem_rd <= 5'd0;
      memwb_rw <= 1'b0;
      memwb_rd <= 5'd0;
      fwd_q    <= '0;
      cnt_q    <= '0;
    end else begin
      exmem_rw <= hz.id_ex_reg_write;
      exmem_rd <= hz.id_ex_rd;
      memwb_rw <= exmem_rw;
      memwb_rd <= exmem_rd;
      fwd_q    <= (hz.flush || stall) ? '0 : fwd_nxt;
      if (stall && (cnt_q != CNT_MAX))
        cnt_q <= cnt_q + 1'b1;
    end
  end

  assign hz.forward_a   = fwd_q[0];
  assign hz.forward_b   = fwd_q[1];
  assign hz.stall       = stall;
  assign hz.stall_count = cnt_q;
endmodule

// File: tb/tb_mips32_fwd_hazard_unit.sv
// Randomized pipeline-driven bench with a scoreboard for forward selects, stall and counter.
module tb_mips32_fwd_hazard_unit;
  localparam int CNT_W   = 2;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mips32_fwd_hazard_unit_if #(.CNT_W(CNT_W)) hz ();
  mips32_fwd_hazard_unit #(.CNT_W(CNT_W)) dut (.clk(clk), .reset(reset), .hz(hz));

  typedef struct { int rs; int rt; int rd; bit uses_rt; bit rw; bit mr; } instr_t;
  typedef struct { int fa; int fb; int cnt; } exp_t;

  exp_t   q[$];
  bit     sq[$];
  int     checks = 0;
  int     errors = 0;
  instr_t id_i, ex_i, m_prev, bubble;
  int     m_cnt;
  bit     fl;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic instr_t rand_instr();
    instr_t r;
    r.rs      = $urandom_range(0, 3);
    r.rt      = $urandom_range(0, 3);
    r.rd      = $urandom_range(0, 3);
    r.uses_rt = ($urandom_range(0, 3) != 0);
    r.rw      = ($urandom_range(0, 4) != 0);
    r.mr      = ($urandom_range(0, 2) == 0);
    return r;
  endfunction

  // Writers that will be ahead of the ID instruction when it reaches EX, newest first
  function automatic int ref_fwd(int s, bit en);
    instr_t wr[2];
    wr[0] = ex_i;
    wr[1] = m_prev;
    if (!en || s == 0) return 0;
    for (int age = 0; age < 2; age++)
      if (wr[age].rw && wr[age].rd == s) return (age == 0) ? 2 : 1;
    return 0;
  endfunction

  function automatic bit ref_stall();
    bit needs = (ex_i.rd == id_i.rs) || (id_i.uses_rt && ex_i.rd == id_i.rt);
    return ex_i.mr && ex_i.rw && ex_i.rd != 0 && needs && !fl;
  endfunction

  task automatic drive();
    hz.flush           = fl;
    hz.id_rs           = 5'(id_i.rs);
    hz.id_rt           = 5'(id_i.rt);
    hz.id_uses_rt      = id_i.uses_rt;
    hz.id_ex_rd        = 5'(ex_i.rd);
    hz.id_ex_reg_write = ex_i.rw;
    hz.id_ex_mem_read  = ex_i.mr;
  endtask

  task automatic step();
    exp_t e;
    bit   st;
    fl = ($urandom_range(0, 7) == 0);
    drive();
    st    = ref_stall();
    e.fa  = (fl || st) ? 0 : ref_fwd(id_i.rs, 1'b1);
    e.fb  = (fl || st) ? 0 : ref_fwd(id_i.rt, id_i.uses_rt);
    m_cnt = (st && m_cnt < CNT_MAX) ? m_cnt + 1 : m_cnt;
    e.cnt = m_cnt;
    q.push_back(e);
    sq.push_back(st);
    m_prev = ex_i;
    // Advance the mini pipeline: a stall holds ID and bubbles EX, a flush discards ID
    if (st) begin
      ex_i = bubble;
    end else if (fl) begin
      ex_i = bubble;
      id_i = rand_instr();
    end else begin
      ex_i = id_i;
      id_i = rand_instr();
    end
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("forward_a", int'(hz.forward_a), e.fa);
      chk("forward_b", int'(hz.forward_b), e.fb);
      chk("stall_count", int'(hz.stall_count), e.cnt);
    end
  end

  always @(negedge clk) begin
    bit s;
    if (sq.size() > 0) begin
      s = sq.pop_front();
      chk("stall", int'(hz.stall), int'(s));
    end
  end

  task automatic model_clear();
    ex_i   = bubble;
    m_prev = bubble;
    m_cnt  = 0;
    fl     = 1'b0;
    id_i   = rand_instr();
  endtask

  initial begin
    bit st_now;
    bubble = '{rs: 0, rt: 0, rd: 0, uses_rt: 1'b0, rw: 1'b0, mr: 1'b0};
    model_clear();
    ex_i  = bubble;
    reset = 1'b0;
    id_i  = bubble;
    drive();
    #2;
    chk("reset forward_a", int'(hz.forward_a), 0);
    chk("reset forward_b", int'(hz.forward_b), 0);
    chk("reset stall_count", int'(hz.stall_count), 0);
    chk("reset stall", int'(hz.stall), 0);
    repeat (2) @(negedge clk);
    #1 reset = 1'b1;
    id_i = rand_instr();

    for (int i = 0; i < 600; i++) begin
      @(posedge clk);
      #2;
      step();
      if (i == 300) begin
        st_now = sq[$];
        #1 reset = 1'b0;
        #1;
        chk("async reset forward_a", int'(hz.forward_a), 0);
        chk("async reset forward_b", int'(hz.forward_b), 0);
        chk("async reset stall_count", int'(hz.stall_count), 0);
        chk("stall during reset", int'(hz.stall), int'(st_now));
        q.delete();
        sq.delete();
        model_clear();
        id_i = bubble;
        drive();
        #1;
        chk("stall after inputs clear", int'(hz.stall), 0);
        id_i = rand_instr();
        @(negedge clk);
        #1 reset = 1'b1;
      end
    end

    repeat (3) @(posedge clk);
    #3;
    chk("scoreboard drained", q.size() + sq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
